// File: rtl/uart_cpld_responder.sv
// Byte-wide host-bus UART with a single transmit holding register and a single receive holding register.
// Define PARITY_EN to add an even-parity bit (8E1 framing); the default build uses 8N1 framing.
module uart_cpld_responder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrn,
    input  logic       rdn,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tbre,
    output logic       tsre,
    output logic       data_ready,
    output logic       txd,
    input  logic       rxd,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic wr_q, rd_q, wr_edge, rd_edge;
    assign wr_edge = wr_q & ~wrn;
    assign rd_edge = rd_q & ~rdn;

    // ---------------- transmitter ----------------
    state_t          tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_idx, tx_idx_n;
    logic [7:0]      thr, tx_byte;
    logic            txd_n, tsre_n, tx_load;

    // NOTE: every next-state signal gets its default first so no latch is inferred.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = (tx_cnt == BIT_LAST) ? '0 : tx_cnt + CW'(1);
        tx_idx_n   = tx_idx;
        txd_n      = txd;
        tsre_n     = tsre;
        tx_load    = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (!tbre) begin
                    tx_load    = 1'b1;
                    tx_state_n = S_START;
                    txd_n      = 1'b0;
                    tsre_n     = 1'b0;
                end
            end
            S_START: if (tx_cnt == BIT_LAST) begin
                tx_state_n = S_DATA;
                tx_idx_n   = '0;
                txd_n      = tx_byte[0];
            end
            S_DATA: if (tx_cnt == BIT_LAST) begin
                if (tx_idx != 3'd7) begin
                    tx_idx_n = tx_idx + 3'd1;
                    txd_n    = tx_byte[tx_idx + 3'd1];
                end else begin
`ifdef PARITY_EN
                    tx_state_n = S_PARITY;
                    txd_n      = ^tx_byte;
`else
                    tx_state_n = S_STOP;
                    txd_n      = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            S_PARITY: if (tx_cnt == BIT_LAST) begin
                tx_state_n = S_STOP;
                txd_n      = 1'b1;
            end
`endif
            S_STOP: if (tx_cnt == BIT_LAST) begin
                // A full THR chains straight into the next start bit with no idle gap.
                if (!tbre) begin
                    tx_load    = 1'b1;
                    tx_state_n = S_START;
                    txd_n      = 1'b0;
                end else begin
                    tx_state_n = S_IDLE;
                    tsre_n     = 1'b1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            thr      <= '0;
            tbre     <= 1'b1;
            tsre     <= 1'b1;
            txd      <= 1'b1;
        end else begin
            wr_q     <= wrn;
            rd_q     <= rdn;
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tsre     <= tsre_n;
            txd      <= txd_n;
            if (tx_load) tx_byte <= thr;
            // The THR counts as empty in the same cycle it is drained to the shifter.
            if (wr_edge && (tbre || tx_load)) begin
                thr  <= wdata;
                tbre <= 1'b0;
            end else if (tx_load) begin
                tbre <= 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    state_t          rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_idx, rx_idx_n;
    logic [7:0]      rx_shift, rx_shift_n;
    logic            rx_s1, rx_s2, rx_prev;
    logic            rx_done, frame_err_n;
`ifdef PARITY_EN
    logic            rx_pbit, rx_pbit_n, parity_err_n;
`endif

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = (rx_cnt == BIT_LAST) ? '0 : rx_cnt + CW'(1);
        rx_idx_n    = rx_idx;
        rx_shift_n  = rx_shift;
        rx_done     = 1'b0;
        frame_err_n = 1'b0;
`ifdef PARITY_EN
        rx_pbit_n    = rx_pbit;
        parity_err_n = 1'b0;
`endif
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = S_START;
            end
            S_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_n   = '0;
                rx_idx_n   = '0;
                rx_state_n = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt == BIT_LAST) begin
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_idx_n   = rx_idx + 3'd1;
`ifdef PARITY_EN
                if (rx_idx == 3'd7) rx_state_n = S_PARITY;
`else
                if (rx_idx == 3'd7) rx_state_n = S_STOP;
`endif
            end
`ifdef PARITY_EN
            S_PARITY: if (rx_cnt == BIT_LAST) begin
                rx_pbit_n  = rx_s2;
                rx_state_n = S_STOP;
            end
`endif
            S_STOP: if (rx_cnt == BIT_LAST) begin
                rx_state_n = S_IDLE;
                if (rx_s2) begin
                    rx_done = 1'b1;
`ifdef PARITY_EN
                    parity_err_n = rx_pbit ^ (^rx_shift);
`endif
                end else begin
                    frame_err_n = 1'b1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rdata      <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rxd;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_idx     <= rx_idx_n;
            rx_shift   <= rx_shift_n;
            frame_err  <= frame_err_n;
            // A completing byte beats a simultaneous read; overrun is then left as is.
            if (rx_done) begin
                rdata      <= rx_shift;
                data_ready <= 1'b1;
                if (data_ready && !rd_edge) overrun <= 1'b1;
            end else if (rd_edge) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_pbit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_pbit    <= rx_pbit_n;
            parity_err <= parity_err_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
